// File: rtl/led_uart_tx.sv
// led_uart_tx: serial output stage for the mini-ALU LED port.
// Bytes strobed in on iValid are buffered in a small FIFO and sent
// LSB-first as asynchronous frames (8N1, or 8E1 when LED_UART_PARITY_EN
// is defined) on oTx.
//
// Ports:
//   Clock      in   system clock, rising-edge
//   Reset      in   asynchronous active-low reset
//   iData[7:0] in   byte to send
//   iValid     in   one-cycle write strobe
//   oReady     out  FIFO not full
//   oTx        out  serial line, idles high
//   oBusy      out  frame on the line or FIFO non-empty
//   oOverflow  out  sticky: a byte was dropped on a full FIFO
//
// Optional feature macro: LED_UART_PARITY_EN (even-parity bit after bit 7).
module led_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iValid,
    output logic       oReady,
    output logic       oTx,
    output logic       oBusy,
    output logic       oOverflow
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef LED_UART_PARITY_EN
        , PARITY
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                overflow_q, overflow_d;
`ifdef LED_UART_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [7:0]          head;
    logic                push;
    logic                pop;
    logic                baud_last;
    logic                fifo_empty;

    assign head       = mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign baud_last  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    // Acceptance uses registered readiness only, so a full FIFO refuses a push
    // even when a pop happens on the same edge.
    assign push       = iValid & ready_q;

    // Next-state logic for the transmitter FSM, FIFO and output flags.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (iValid & ~ready_q);
        tx_d       = 1'b1;
`ifdef LED_UART_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) state_d = DATA;
            end
            DATA: begin
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef LED_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef LED_UART_PARITY_EN
            PARITY: begin
                if (baud_last) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit.
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d  = head;
            bit_d    = 3'd0;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
`ifdef LED_UART_PARITY_EN
            parity_d = ^head;
`endif
        end

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Baud counter restarts on every state change and rests at 0 in IDLE.
        if ((state_d != state_q) || (state_q == IDLE)) begin
            baud_d = '0;
        end else if (baud_last) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        // Line level is a function of the next state so oTx is a clean flop.
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef LED_UART_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        busy_d  = (state_d != IDLE) | (count_d != '0);
        ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    end

    // State and flag registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
`ifdef LED_UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
`ifdef LED_UART_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge Clock) begin
        if (push) mem_q[wr_ptr_q] <= iData;
    end

    assign oTx       = tx_q;
    assign oBusy     = busy_q;
    assign oReady    = ready_q;
    assign oOverflow = overflow_q;

endmodule

// File: tb/tb_led_uart_tx.sv
// tb_led_uart_tx: directed self-checking bench for led_uart_tx
// (CLKS_PER_BIT=4, FIFO_DEPTH=4). Outputs are sampled on the falling edge.
module tb_led_uart_tx;

    logic       Clock;
    logic       Reset;
    logic [7:0] iData;
    logic       iValid;
    logic       oReady;
    logic       oTx;
    logic       oBusy;
    logic       oOverflow;

    int vectors = 0;
    int errors  = 0;

    led_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iData    (iData),
        .iValid   (iValid),
        .oReady   (oReady),
        .oTx      (oTx),
        .oBusy    (oBusy),
        .oOverflow(oOverflow)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called on the falling edge right after the start bit begins; returns
    // on the falling edge of the last stop-bit cycle.
    task automatic expect_frame(input logic [7:0] b);
        check("start_c0", oTx, 1'b0);
        repeat (3) @(negedge Clock);
        check("start_c3", oTx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (2) @(negedge Clock);
            check("data_c1", oTx, b[i]);
            repeat (2) @(negedge Clock);
            check("data_c3", oTx, b[i]);
        end
`ifdef LED_UART_PARITY_EN
        repeat (2) @(negedge Clock);
        check("parity_c1", oTx, ^b);
        repeat (2) @(negedge Clock);
        check("parity_c3", oTx, ^b);
`endif
        repeat (2) @(negedge Clock);
        check("stop_c1", oTx, 1'b1);
        repeat (2) @(negedge Clock);
        check("stop_c3", oTx, 1'b1);
        check("busy_in_frame", oBusy, 1'b1);
    endtask

    initial begin
        logic saw_low;

        // Reset and quiet idle line
        Reset  = 1'b1;
        iValid = 1'b0;
        iData  = 8'h00;
        #1 Reset = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("rst_tx", oTx, 1'b1);
        check("rst_ready", oReady, 1'b1);
        check("rst_busy", oBusy, 1'b0);
        check("rst_ovf", oOverflow, 1'b0);
        saw_low = 1'b0;
        repeat (50) begin
            @(negedge Clock);
            if (oTx !== 1'b1) saw_low = 1'b1;
        end
        check("idle_quiet", saw_low, 1'b0);

        // Single byte 0xA5: push at edge N, start bit after N+1
        iData  = 8'hA5;
        iValid = 1'b1;
        @(negedge Clock);
        iValid = 1'b0;
        check("single_tx_n", oTx, 1'b1);
        check("single_busy_n", oBusy, 1'b1);
        check("single_ready_n", oReady, 1'b1);
        @(negedge Clock);
        expect_frame(8'hA5);
        @(negedge Clock);
        check("single_busy_fall", oBusy, 1'b0);
        check("single_tx_idle", oTx, 1'b1);

        // Burst 0x01,0x02,0x03 on consecutive edges, no idle gap
        repeat (3) @(negedge Clock);
        iData  = 8'h01;
        iValid = 1'b1;
        @(negedge Clock);
        iData = 8'h02;
        @(negedge Clock);
        iData = 8'h03;
        fork
            begin
                @(negedge Clock);
                iValid = 1'b0;
            end
        join_none
        expect_frame(8'h01);
        @(negedge Clock);
        expect_frame(8'h02);
        @(negedge Clock);
        expect_frame(8'h03);
        @(negedge Clock);
        check("burst_busy_fall", oBusy, 1'b0);

        // Overflow: 0x10..0x15 on consecutive edges, 0x15 dropped
        repeat (3) @(negedge Clock);
        check("pre_ovf", oOverflow, 1'b0);
        iData  = 8'h10;
        iValid = 1'b1;
        fork
            begin
                for (int i = 1; i < 6; i++) begin
                    @(negedge Clock);
                    if (i == 4) begin
                        check("ovf_ready_3", oReady, 1'b1);
                        check("ovf_flag_clear", oOverflow, 1'b0);
                    end
                    if (i == 5) check("ovf_ready_full", oReady, 1'b0);
                    iData = 8'h10 + 8'(i);
                end
                @(negedge Clock);
                check("ovf_flag_set", oOverflow, 1'b1);
                check("ovf_ready_full2", oReady, 1'b0);
                iValid = 1'b0;
            end
        join_none
        repeat (2) @(negedge Clock);
        expect_frame(8'h10);
        for (int k = 1; k < 5; k++) begin
            @(negedge Clock);
            expect_frame(8'h10 + 8'(k));
        end
        @(negedge Clock);
        check("ovf_busy_fall", oBusy, 1'b0);
        check("ovf_sticky", oOverflow, 1'b1);
        check("ovf_ready_back", oReady, 1'b1);

        // Push on the last stop cycle while one byte is buffered
        repeat (3) @(negedge Clock);
        iData  = 8'h3C;
        iValid = 1'b1;
        @(negedge Clock);
        iData = 8'hC3;
        fork
            begin
                @(negedge Clock);
                iValid = 1'b0;
            end
        join_none
        @(negedge Clock);
        expect_frame(8'h3C);
        iData  = 8'h5A;
        iValid = 1'b1;
        fork
            begin
                @(negedge Clock);
                iValid = 1'b0;
            end
        join_none
        @(negedge Clock);
        check("pp_ready", oReady, 1'b1);
        expect_frame(8'hC3);
        @(negedge Clock);
        expect_frame(8'h5A);
        @(negedge Clock);
        check("pp_busy_fall", oBusy, 1'b0);

        // Asynchronous reset during a start bit drives the line high at once
        repeat (3) @(negedge Clock);
        iData  = 8'h00;
        iValid = 1'b1;
        @(negedge Clock);
        iValid = 1'b0;
        @(negedge Clock);
        check("ares_start_low", oTx, 1'b0);
        #2 Reset = 1'b0;
        #1;
        check("ares_tx_high", oTx, 1'b1);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("ares_busy", oBusy, 1'b0);

        // Reset during bit 3 of 0xFF with two bytes queued
        repeat (3) @(negedge Clock);
        iData  = 8'hFF;
        iValid = 1'b1;
        @(negedge Clock);
        iData = 8'h01;
        @(negedge Clock);
        iData = 8'h02;
        fork
            begin
                @(negedge Clock);
                iValid = 1'b0;
            end
        join_none
        repeat (17) @(negedge Clock);
        check("mid_bit3", oTx, 1'b1);
        check("mid_busy_pre", oBusy, 1'b1);
        check("mid_ready_pre", oReady, 1'b1);
        #2 Reset = 1'b0;
        #1;
        check("mid_tx", oTx, 1'b1);
        check("mid_busy", oBusy, 1'b0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge Clock);
            if (oTx !== 1'b1) saw_low = 1'b1;
        end
        check("mid_no_frame", saw_low, 1'b0);
        check("mid_busy_after", oBusy, 1'b0);
        check("mid_ovf_after", oOverflow, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/led_uart_tx.md
# led_uart_tx

Serial output stage for the mini-ALU core. It captures each byte the core writes to its LED port (the `LED` instruction strobe), buffers it in a small FIFO, and transmits it LSB-first as an asynchronous 8N1 frame on a single TX line. The block lets a host terminal log program output without stalling the pipeline.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200 baud). Must be ≥ 2.
- `FIFO_DEPTH`, default 4: entries in the byte buffer. Must be a power of two, ≥ 2.
- `Clock`  in  1  system clock. All logic is rising-edge triggered.
- `Reset`  in  1  asynchronous, active-low reset (0 = reset).
- `iData`  in  8  byte to send. This is the same value latched into the LED register.
- `iValid`  in  1  write strobe, one cycle per byte. Driven by the LED-enable decode.
- `oReady`  out  1  FIFO not full.
- `oTx`  out  1  serial line. Idle level is 1.
- `oBusy`  out  1  asserted while a frame is on the line or the FIFO is non-empty.
- `oOverflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.

## Operation
- **Push.** On a rising edge with `iValid`=1 and `oReady`=1, `iData` is written at the write pointer and the count increments.
- **Full FIFO.** With `iValid`=1 and `oReady`=0, the byte is discarded and `oOverflow` is set to 1. `oOverflow` clears only on reset.
- **`oReady`.** It is `count != FIFO_DEPTH`, taken from registered state only. A push on a full FIFO is refused even if a pop happens on the same edge.
- **Simultaneous push and pop.** Count is unchanged and both pointers advance.
- **Pointer wrap.** Pointers are `log2(FIFO_DEPTH)` bits wide and wrap modulo `FIFO_DEPTH`. The count is `log2(FIFO_DEPTH)+1` bits.
- **FSM states:** `IDLE`, `START`, `DATA`, `PARITY` (only with the macro), `STOP`.
- **`IDLE`:** `oTx`=1. If the FIFO is non-empty: pop the head into the shift register, clear the bit counter, go to `START`.
- **`START`:** `oTx`=0 for `CLKS_PER_BIT` cycles, then go to `DATA`.
- **`DATA`:** `oTx` = shift[0]. After each `CLKS_PER_BIT` cycles, shift right and increment the bit index. After bit 7, go to `PARITY` or `STOP`.
- **`STOP`:** `oTx`=1 for `CLKS_PER_BIT` cycles. On the last cycle:
  - FIFO non-empty: pop and go directly to `START` (no idle gap).
  - FIFO empty: go to `IDLE`.
- **Baud counter.** Counts 0 … `CLKS_PER_BIT`-1 and reloads to 0 on every state change.
- **`oBusy`.** Defined as `(state != IDLE) | (count != 0)`.
- **Output register.** `oTx` is registered, so it carries no combinational glitches.

## Timing
- **Reset values:** `oTx`=1, `oReady`=1, `oBusy`=0, `oOverflow`=0, state `IDLE`, FIFO empty.
- **Reset mid-frame:** the line returns to 1 immediately (asynchronously), the FIFO is flushed and the partial frame is lost.
- **Latency:** a byte accepted at edge N into an empty, idle block is popped at edge N+1. `oTx` falls after edge N+1.
- **Frame length:** 10·`CLKS_PER_BIT` cycles (11·`CLKS_PER_BIT` with parity).
- **Back-to-back frames:** consecutive buffered bytes are sent with zero idle cycles between the stop bit and the next start bit.
- **`oBusy` timing:** `oBusy` rises at edge N (the push edge). It falls on the edge that enters `IDLE` with an empty FIFO.

## Configuration
- Macro `LED_UART_PARITY_EN`.
- **Defined:** the `PARITY` state is inserted after bit 7. It drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles, giving an 8E1 frame of 11 bits.
- **Undefined:** the `PARITY` state and its logic are not compiled. The frame is 8N1, 10 bits.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.

- **Reset:** hold `Reset`=0 for 3 cycles, release → `oTx`=1, `oReady`=1, `oBusy`=0, `oOverflow`=0. No `oTx` transition for 50 cycles.
- **Single byte:** push 0xA5 at edge N → `oTx` low for cycles N+1…N+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1. `oBusy` falls at edge N+41. With parity: an extra 0 bit, and `oBusy` falls at edge N+45.
- **Burst:** push 0x01, 0x02, 0x03 on consecutive edges → three frames with no idle cycle between frames. `oBusy` stays 1 throughout the burst.
- **Overflow:** push 6 bytes 0x10…0x15 on consecutive edges → first 5 accepted (one popped immediately). `oReady`=0 while 4 are buffered. 0x15 is dropped and `oOverflow`=1. The line carries 0x10…0x14.
- **Push/pop on same edge:** push on the last `STOP` cycle with 1 byte buffered → count stays 1 and frame order is preserved.
- **Reset mid-frame:** assert `Reset` during bit 3 of 0xFF with 2 bytes queued → `oTx`=1 at once. After release, no frame is sent and `oBusy`=0.
